// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types, constants and helpers for the writeback arbiter
//
// Purpose: unit identifiers, FIFO sizing and the buffered result record used by
//          wb_arbiter, wb_fifo and their bench.
// Ports:   none (package). Supplies default `WORD_SIZE / `ROB_ENTRY_WIDTH when the
//          surrounding build does not define them.

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

package wb_arbiter_pkg;

   typedef enum logic [1:0] {
      FU_ALU = 2'd0,
      FU_MEM = 2'd1,
      FU_MUL = 2'd2
   } fu_id_t;

   localparam int NUM_FU        = 3;
   localparam int WB_FIFO_DEPTH = 2;

   typedef struct packed {
      logic [`ROB_ENTRY_WIDTH-1:0] rob_id;
      logic [`WORD_SIZE-1:0]       data;
   } wb_result_t;

   // (base + step) mod 3, for step in 0..2
   function automatic fu_id_t fu_rotate(fu_id_t base, logic [1:0] step);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, step};
      if (sum >= 3'd3) begin
         sum = sum - 3'd3;
      end
      return fu_id_t'(sum[1:0]);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - two-entry result FIFO with flush, one per functional unit
//
// Purpose: buffers completed results of one unit until the arbiter grants them.
// Ports:   clk, rst (async, active-low); push/din write an entry unless full;
//          pop retires the head unless empty; flush empties the FIFO (wins over
//          push/pop); head is the oldest entry; empty/full report occupancy.

import wb_arbiter_pkg::*;

module wb_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = WB_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam logic [1:0] DEPTH_C = 2'(DEPTH);

   logic [WIDTH-1:0] mem_q [2];
   logic             rd_q, rd_d;
   logic             wr_q, wr_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == 2'd0);
   assign full    = (cnt_q == DEPTH_C);
   assign head    = mem_q[rd_q];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush) begin
         rd_d  = 1'b0;
         wr_d  = 1'b0;
         cnt_d = 2'd0;
      end else begin
         if (do_push) wr_d = ~wr_q;
         if (do_pop)  rd_d = ~rd_q;
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= 2'd0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         if (do_push) mem_q[wr_q] <= din;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter for the ALU, MEM and MUL results
//
// Purpose: buffers each unit's results in a 2-entry FIFO and grants one per cycle,
//          round-robin, onto the ROB write / bypass bus. Optional macro
//          WB_ARB_BYPASS_EN lets an input whose FIFO is empty win directly.
// Ports:   clk, rst (async, active-low)
//          <unit>_valid/_data/_rob_id : result offered by alu, mem, mul
//          <unit>_stall               : that unit's FIFO is full
//          rob_wr_ready               : ROB accepts a write this cycle
//          jump_taken                 : discard all buffered and incoming results
//          wb_valid/_data/_rob_id/_fu : granted result (all zero when idle)

import wb_arbiter_pkg::*;

module wb_arbiter #(
   parameter int WORD_SIZE  = `WORD_SIZE,
   parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alu_valid,
   input  logic [WORD_SIZE-1:0]        alu_data,
   input  logic [`ROB_ENTRY_WIDTH-1:0] alu_rob_id,
   input  logic                        mem_valid,
   input  logic [WORD_SIZE-1:0]        mem_data,
   input  logic [`ROB_ENTRY_WIDTH-1:0] mem_rob_id,
   input  logic                        mul_valid,
   input  logic [WORD_SIZE-1:0]        mul_data,
   input  logic [`ROB_ENTRY_WIDTH-1:0] mul_rob_id,
   output logic                        alu_stall,
   output logic                        mem_stall,
   output logic                        mul_stall,
   input  logic                        rob_wr_ready,
   input  logic                        jump_taken,
   output logic                        wb_valid,
   output logic [WORD_SIZE-1:0]        wb_data,
   output logic [`ROB_ENTRY_WIDTH-1:0] wb_rob_id,
   output logic [1:0]                  wb_fu
);

   localparam int ROBW = `ROB_ENTRY_WIDTH;
   localparam int RW   = WORD_SIZE + ROBW;

   logic [NUM_FU-1:0] in_valid, fifo_empty, fifo_full;
   logic [NUM_FU-1:0] push, pop, req, use_in, grant;
   logic [RW-1:0]     in_res    [NUM_FU];
   logic [RW-1:0]     fifo_head [NUM_FU];
   logic [RW-1:0]     cand      [NUM_FU];
   logic [RW-1:0]     win;
   fu_id_t            rr_ptr_q, rr_ptr_d;
   fu_id_t            gnt_fu, idx;
   logic              gnt_any;

   assign in_valid          = {mul_valid, mem_valid, alu_valid};
   assign in_res[FU_ALU]    = {alu_rob_id, alu_data};
   assign in_res[FU_MEM]    = {mem_rob_id, mem_data};
   assign in_res[FU_MUL]    = {mul_rob_id, mul_data};
   assign {mul_stall, mem_stall, alu_stall} = fifo_full;

   // Candidate per unit: the FIFO head, or (bypass build) the live input when
   // the FIFO is empty.
   always_comb begin
      use_in = '0;
      req    = '0;
      for (int i = 0; i < NUM_FU; i++) begin
`ifdef WB_ARB_BYPASS_EN
         use_in[i] = fifo_empty[i] && in_valid[i] && !jump_taken;
`else
         use_in[i] = 1'b0;
`endif
         req[i]  = !fifo_empty[i] || use_in[i];
         cand[i] = use_in[i] ? in_res[i] : fifo_head[i];
      end
   end

   // First requester found starting at rr_ptr wins.
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_fu  = FU_ALU;
      idx     = FU_ALU;
      if (rob_wr_ready && !jump_taken) begin
         for (int k = 0; k < NUM_FU; k++) begin
            idx = fu_rotate(rr_ptr_q, 2'(k));
            if (!gnt_any && req[idx]) begin
               grant[idx] = 1'b1;
               gnt_any    = 1'b1;
               gnt_fu     = idx;
            end
         end
      end
      rr_ptr_d = gnt_any ? fu_rotate(gnt_fu, 2'd1) : rr_ptr_q;
   end

   // A bypassed input that wins is consumed directly; one that loses is stored.
   always_comb begin
      push = in_valid & ~fifo_full & ~(use_in & grant);
      if (jump_taken) push = '0;
      pop = grant & ~use_in;
   end

   always_comb begin
      win       = cand[gnt_fu];
      wb_valid  = gnt_any;
      wb_data   = gnt_any ? win[WORD_SIZE-1:0] : '0;
      wb_rob_id = gnt_any ? win[RW-1:WORD_SIZE] : '0;
      wb_fu     = gnt_any ? gnt_fu : 2'd0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= FU_ALU;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
      wb_fifo #(
         .WIDTH (RW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push[g]),
         .pop   (pop[g]),
         .flush (jump_taken),
         .din   (in_res[g]),
         .head  (fifo_head[g]),
         .empty (fifo_empty[g]),
         .full  (fifo_full[g])
      );
   end

`ifndef SYNTHESIS
   // Producers must honour their stall; a push into a full FIFO is dropped.
   overflow_a : assert property (@(posedge clk) disable iff (!rst)
      !(|(in_valid & fifo_full) && !jump_taken))
      else $error("wb_arbiter: result offered to a full FIFO was dropped");
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

import wb_arbiter_pkg::*;

module tb_wb_arbiter;

   localparam int W = `WORD_SIZE;
   localparam int R = `ROB_ENTRY_WIDTH;

   logic         clk = 1'b0;
   logic         rst;
   logic         alu_valid, mem_valid, mul_valid;
   logic [W-1:0] alu_data, mem_data, mul_data;
   logic [R-1:0] alu_rob_id, mem_rob_id, mul_rob_id;
   logic         alu_stall, mem_stall, mul_stall;
   logic         rob_wr_ready, jump_taken;
   logic         wb_valid;
   logic [W-1:0] wb_data;
   logic [R-1:0] wb_rob_id;
   logic [1:0]   wb_fu;

   int checks   = 0;
   int failures = 0;

   wb_result_t sb_alu[$];
   wb_result_t sb_mem[$];
   wb_result_t sb_mul[$];

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_data     (alu_data),
      .alu_rob_id   (alu_rob_id),
      .mem_valid    (mem_valid),
      .mem_data     (mem_data),
      .mem_rob_id   (mem_rob_id),
      .mul_valid    (mul_valid),
      .mul_data     (mul_data),
      .mul_rob_id   (mul_rob_id),
      .alu_stall    (alu_stall),
      .mem_stall    (mem_stall),
      .mul_stall    (mul_stall),
      .rob_wr_ready (rob_wr_ready),
      .jump_taken   (jump_taken),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_rob_id    (wb_rob_id),
      .wb_fu        (wb_fu)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic sb_clear();
      sb_alu.delete();
      sb_mem.delete();
      sb_mul.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 1'b0; alu_data = '0; alu_rob_id = '0;
      mem_valid = 1'b0; mem_data = '0; mem_rob_id = '0;
      mul_valid = 1'b0; mul_data = '0; mul_rob_id = '0;
   endtask

   // Offer a result; it is expected on wb_* unless this is a flush cycle.
   task automatic put(input int fu, input logic [W-1:0] d, input logic [R-1:0] r);
      wb_result_t e;
      e.data   = d;
      e.rob_id = r;
      case (fu)
         0: begin alu_valid = 1'b1; alu_data = d; alu_rob_id = r; if (!jump_taken) sb_alu.push_back(e); end
         1: begin mem_valid = 1'b1; mem_data = d; mem_rob_id = r; if (!jump_taken) sb_mem.push_back(e); end
         default: begin mul_valid = 1'b1; mul_data = d; mul_rob_id = r; if (!jump_taken) sb_mul.push_back(e); end
      endcase
   endtask

   // Scoreboard: every granted result must match the oldest expected one of its unit.
   always @(negedge clk) begin
      wb_result_t e;
      if (rst && wb_valid) begin
         checks++;
         case (wb_fu)
            2'd0: if (sb_alu.size() > 0) e = sb_alu.pop_front(); else e = '1;
            2'd1: if (sb_mem.size() > 0) e = sb_mem.pop_front(); else e = '1;
            2'd2: if (sb_mul.size() > 0) e = sb_mul.pop_front(); else e = '1;
            default: e = '1;
         endcase
         if (e.data !== wb_data || e.rob_id !== wb_rob_id) begin
            failures++;
            $display("FAIL sb_fu%0d actual=%0h/%0h expected=%0h/%0h",
                     wb_fu, wb_data, wb_rob_id, e.data, e.rob_id);
         end
      end
   end

   typedef struct {
      logic       a, m, x, rdy, jmp;
      logic       ev;
      logic [1:0] efu;
      logic [2:0] estall;   // {mul, mem, alu}
   } vec_t;

   vec_t tbl[26];

   function automatic vec_t mk(logic a, logic m, logic x, logic rdy, logic jmp,
                               logic ev, logic [1:0] efu, logic [2:0] estall);
      vec_t v;
      v.a = a; v.m = m; v.x = x; v.rdy = rdy; v.jmp = jmp;
      v.ev = ev; v.efu = efu; v.estall = estall;
      return v;
   endfunction

   task automatic reset_dut();
      idle();
      rob_wr_ready = 1'b0;
      jump_taken   = 1'b0;
      rst = 1'b0;
      sb_clear();
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[$];
      logic expv;

      // MUL backlog / stall, rr freeze under !ready, flush keeps rr.
      tbl[0]  = mk(0,0,1, 0,0, 0,2'd0,3'b000);
      tbl[1]  = mk(0,0,1, 0,0, 0,2'd0,3'b000);
      tbl[2]  = mk(0,0,0, 0,0, 0,2'd0,3'b100);
      tbl[3]  = mk(0,0,0, 1,0, 1,2'd2,3'b100);
      tbl[4]  = mk(0,0,0, 1,0, 1,2'd2,3'b000);
      tbl[5]  = mk(0,0,0, 1,0, 0,2'd0,3'b000);
      tbl[6]  = mk(1,0,0, 0,0, 0,2'd0,3'b000);
      tbl[7]  = mk(0,0,0, 1,0, 1,2'd0,3'b000);
      tbl[8]  = mk(1,1,1, 0,0, 0,2'd0,3'b000);
      tbl[9]  = mk(0,0,0, 0,0, 0,2'd0,3'b000);
      tbl[10] = mk(0,0,0, 0,0, 0,2'd0,3'b000);
      tbl[11] = mk(0,0,0, 0,0, 0,2'd0,3'b000);
      tbl[12] = mk(0,0,0, 0,0, 0,2'd0,3'b000);
      tbl[13] = mk(0,0,0, 1,0, 1,2'd1,3'b000);
      tbl[14] = mk(0,0,0, 1,0, 1,2'd2,3'b000);
      tbl[15] = mk(0,0,0, 1,0, 1,2'd0,3'b000);
      tbl[16] = mk(0,0,0, 1,0, 0,2'd0,3'b000);
      tbl[17] = mk(1,1,0, 0,0, 0,2'd0,3'b000);
      tbl[18] = mk(1,1,0, 0,0, 0,2'd0,3'b000);
      tbl[19] = mk(0,0,1, 1,1, 0,2'd0,3'b011);
      tbl[20] = mk(0,0,0, 1,0, 0,2'd0,3'b000);
      tbl[21] = mk(1,1,1, 0,0, 0,2'd0,3'b000);
      tbl[22] = mk(0,0,0, 1,0, 1,2'd1,3'b000);
      tbl[23] = mk(0,0,0, 1,0, 1,2'd2,3'b000);
      tbl[24] = mk(0,0,0, 1,0, 1,2'd0,3'b000);
      tbl[25] = mk(0,0,0, 1,0, 0,2'd0,3'b000);

      // Reset values
      rst = 1'b0;
      idle();
      rob_wr_ready = 1'b1;
      jump_taken   = 1'b0;
      tick();
      tick();
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rob_id", wb_rob_id, 0);
      chk("rst_wb_fu", wb_fu, 0);
      chk("rst_stalls", {mul_stall, mem_stall, alu_stall}, 0);
      rst = 1'b1;
      tick();

      // Reset mid-traffic drops buffered results
      rob_wr_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         idle();
         put(0, 32'h70 + i, 4'(i));
         put(1, 32'h80 + i, 4'(i));
         tick();
      end
      idle();
      #3;
      chk("pre_rst_stalls", {mul_stall, mem_stall, alu_stall}, 3'b011);
      tick();
      rst = 1'b0;
      rob_wr_ready = 1'b1;
      sb_clear();
      #1;
      chk("midrst_wb_valid", wb_valid, 0);
      chk("midrst_wb_data", wb_data, 0);
      chk("midrst_wb_rob_id", wb_rob_id, 0);
      chk("midrst_wb_fu", wb_fu, 0);
      chk("midrst_stalls", {mul_stall, mem_stall, alu_stall}, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // First ALU push after reset
      put(0, 32'h11, 4'd3);
      #3;
`ifdef WB_ARB_BYPASS_EN
      chk("t1_same_valid", wb_valid, 1);
      chk("t1_same_fu", wb_fu, 0);
      chk("t1_same_data", wb_data, 32'h11);
`else
      chk("t1_same_valid", wb_valid, 0);
`endif
      tick();
      idle();
      #3;
`ifdef WB_ARB_BYPASS_EN
      chk("t1_next_valid", wb_valid, 0);
`else
      chk("t1_next_valid", wb_valid, 1);
      chk("t1_next_fu", wb_fu, 0);
      chk("t1_next_data", wb_data, 32'h11);
      chk("t1_next_rob", wb_rob_id, 3);
`endif
      tick();

      // All three push together: ALU, MEM, MUL, then rr back at ALU
      reset_dut();
      rob_wr_ready = 1'b1;
      order.delete();
      for (int c = 0; c < 6; c++) begin
         idle();
         if (c == 0) begin
            put(0, 32'hA, 4'd1);
            put(1, 32'hB, 4'd2);
            put(2, 32'hC, 4'd3);
         end
         #3;
         if (wb_valid) order.push_back(int'(wb_fu));
         tick();
      end
      chk("t2_count", order.size(), 3);
      chk("t2_ord0", order.size() > 0 ? order[0] : 99, 0);
      chk("t2_ord1", order.size() > 1 ? order[1] : 99, 1);
      chk("t2_ord2", order.size() > 2 ? order[2] : 99, 2);
      rob_wr_ready = 1'b0;
      put(0, 32'h21, 4'd4);
      put(2, 32'h23, 4'd6);
      tick();
      idle();
      rob_wr_ready = 1'b1;
      #3;
      chk("t2_rr_at_alu", wb_fu, 0);
      tick();
      #3;
      chk("t2_then_mul", wb_fu, 2);
      tick();

      // Table-driven sequence
      reset_dut();
      for (int r = 0; r < 26; r++) begin
         idle();
         rob_wr_ready = tbl[r].rdy;
         jump_taken   = tbl[r].jmp;
         if (tbl[r].jmp) sb_clear();
         if (tbl[r].a) put(0, 32'h100 + r, 4'(r));
         if (tbl[r].m) put(1, 32'h200 + r, 4'(r));
         if (tbl[r].x) put(2, 32'h300 + r, 4'(r));
         #3;
         chk($sformatf("tbl%0d_valid", r), wb_valid, tbl[r].ev);
         if (tbl[r].ev) chk($sformatf("tbl%0d_fu", r), wb_fu, tbl[r].efu);
         chk($sformatf("tbl%0d_stall", r), {mul_stall, mem_stall, alu_stall}, tbl[r].estall);
         tick();
      end
      jump_taken = 1'b0;

      // Continuous ALU stream
      reset_dut();
      rob_wr_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         idle();
         if (i < 10) put(0, 32'h500 + i, 4'(i));
         #3;
`ifdef WB_ARB_BYPASS_EN
         expv = (i < 10);
`else
         expv = (i >= 1);
`endif
         chk($sformatf("t6_valid%0d", i), wb_valid, expv);
         chk($sformatf("t6_stall%0d", i), alu_stall, 0);
         tick();
      end
      idle();
      tick();

      chk("end_sb_alu", sb_alu.size(), 0);
      chk("end_sb_mem", sb_mem.size(), 0);
      chk("end_sb_mul", sb_mul.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
